stc_coeff_loader: RTL
=====================

// Module: stc_coeff_loader
// PURPOSE
//  Executes the STC (store coefficients) instruction. Sits upstream of the EVP
//  stage and fills the N RAM and S RAM that EVP reads. Pops an N token and then
//  N+1 coefficient tokens from the input FIFO. Writes them to vector slot A.
//  Reports completion through done_stc and a 32-bit status word.
// PARAMETERS
//  MAX_N     10   largest legal degree; S RAM stride per vector is MAX_N+1 = 11
//  ERR_N     31   N RAM marker for an invalid vector (5'b11111, the value EVP rejects)
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, asynchronous, active-high
//  start_stc      in   1   start the instruction; sampled only in IDLE
//  A              in   3   target vector index, captured at start
//  fifo_empty     in   1   input FIFO empty flag
//  fifo_in_data   in   16  input FIFO head; valid the cycle after fifo_rd_en
//  fifo_rd_en     out  1   pop one token from the input FIFO
//  wr_en_N        out  1   N RAM write strobe
//  wr_addr_N      out  3   N RAM address (= captured A)
//  wr_data_N      out  5   N RAM write data
//  wr_en_S        out  1   S RAM write strobe
//  wr_addr_S      out  7   S RAM address = A*11 + i
//  wr_data_S      out  16  S RAM write data (raw coefficient)
//  done_stc       out  1   one-cycle completion pulse
//  status         out  32  0 = success, 1 = N out of range; holds until the next STC
// BEHAVIOUR
//  Reset values: all strobes, done_stc and the data/address outputs are 0.
//   status = 32'hFFFFFFFF. State = IDLE. Counter i = 0.
//  State machine:
//   IDLE   : when start_stc=1, capture A and go to RD_N. start_stc is ignored in every other state.
//   RD_N   : hold while fifo_empty. Otherwise pulse fifo_rd_en for 1 cycle and go to CHK_N.
//   CHK_N  : compare the full 16 bits of fifo_in_data (unsigned) against MAX_N.
//            If data > MAX_N: wr_en_N=1, wr_data_N=ERR_N, status<=1, go to END.
//            Else: wr_en_N=1, wr_data_N=data[4:0], latch N, i<=0, go to RD_C.
//   RD_C   : hold while fifo_empty. Otherwise pulse fifo_rd_en and go to WR_C.
//   WR_C   : wr_en_S=1, wr_addr_S=A*11+i, wr_data_S=fifo_in_data.
//            If i==N: status<=0, go to ZFILL (macro on) or END.
//            Else: i<=i+1, go to RD_C.
//   END    : done_stc=1 for this cycle only, then IDLE.
//  Strobes are combinational from state. Each strobe is high exactly 1 cycle per event.
//  fifo_rd_en is never asserted while fifo_empty=1.
//  Latency with a never-empty FIFO: start sampled at cycle 0; RD_N at cycle 1; CHK_N at cycle 2.
//   Each coefficient takes 2 cycles. done_stc is high at cycle 2*N+5. An invalid N gives done at cycle 3.
//  Address arithmetic: A*11+i is computed at 7 bits. The maximum is 7*11+10 = 87, so no wrap.
//  An empty FIFO stalls indefinitely in RD_N or RD_C. There is no timeout.
//  After an invalid N, the remaining coefficient tokens are left in the FIFO.
//   Draining them is the controller's job.
//  Reset mid-operation: return to IDLE immediately and drive outputs to their reset values.
//   Writes already made stay in RAM and are not rolled back.
//   Tokens already popped are lost.
//  Two back-to-back STC starts: a start asserted in the same cycle as done_stc is ignored.
//   The earliest accepted start is the cycle after END.
// CONFIGURATION
//  STC_ZERO_FILL_EN defined: after the last coefficient, enter ZFILL.
//   ZFILL writes wr_data_S=0 to slots i=N+1..MAX_N, one per cycle, with no FIFO pops, then goes to END.
//   If N==MAX_N, ZFILL is skipped and the machine goes straight to END.
//   done_stc then moves to cycle 2*N+5+(MAX_N-N).
//  STC_ZERO_FILL_EN undefined: there is no ZFILL state and unused slots keep their old contents.
// TESTING
//  1. Reset, then start A=2, FIFO={2,5,7,9}:
//     N[2]=2; S[22]=5, S[23]=7, S[24]=9; done at cycle 9; status=0.
//  2. Start A=7, FIFO={10, c0..c10}:
//     writes reach S[77..87]; N[7]=10; done at cycle 25; no ZFILL cycles.
//  3. Start A=0, FIFO={11}:
//     N[0]=31; status=1; done at cycle 3; no S writes; the FIFO is not popped again.
//  4. Start A=1, N=1, FIFO empty for 4 cycles before each coefficient:
//     fifo_rd_en stays low while empty; S[11], S[12] are correct; done is delayed by 8 cycles.
//  5. Assert rst during WR_C of coefficient 1 of a 3-coefficient load:
//     outputs go to reset values; next start_stc is accepted normally; status=FFFFFFFF until END.
//  6. STC_ZERO_FILL_EN defined, A=3, FIFO={1,4,6}:
//     S[33]=4, S[34]=6; S[35..43]=0; done at cycle 16.

Source files
------------

// File: rtl/stc_coeff_loader_if.sv
// rtl/stc_coeff_loader_if.sv - STC loader bus: start/status, input FIFO pop side, N/S RAM write ports
interface stc_coeff_loader_if;
  logic        start_stc;
  logic [2:0]  A;
  logic        fifo_empty;
  logic [15:0] fifo_in_data;
  logic        fifo_rd_en;
  logic        wr_en_N;
  logic [2:0]  wr_addr_N;
  logic [4:0]  wr_data_N;
  logic        wr_en_S;
  logic [6:0]  wr_addr_S;
  logic [15:0] wr_data_S;
  logic        done_stc;
  logic [31:0] status;

  modport master (
    output start_stc, A, fifo_empty, fifo_in_data,
    input  fifo_rd_en, wr_en_N, wr_addr_N, wr_data_N,
    input  wr_en_S, wr_addr_S, wr_data_S, done_stc, status
  );

  modport slave (
    input  start_stc, A, fifo_empty, fifo_in_data,
    output fifo_rd_en, wr_en_N, wr_addr_N, wr_data_N,
    output wr_en_S, wr_addr_S, wr_data_S, done_stc, status
  );
endinterface

// File: rtl/stc_coeff_loader.sv
// rtl/stc_coeff_loader.sv - STC instruction: pops N and N+1 coefficients into N/S RAM slot A
// Optional STC_ZERO_FILL_EN: zero the unused S slots N+1..MAX_N after the last coefficient.
module stc_coeff_loader #(
  parameter int MAX_N = 10,
  parameter int ERR_N = 31
) (
  input  logic                clk,
  input  logic                rst,
  stc_coeff_loader_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_N,
    S_CHK_N,
    S_RD_C,
    S_WR_C,
`ifdef STC_ZERO_FILL_EN
    S_ZFILL,
`endif
    S_END
  } state_t;

  state_t      state, state_d;
  logic [2:0]  a_q;
  logic [3:0]  n_q;
  logic [3:0]  i_q;
  logic [31:0] status_q;

  logic        n_ok;
  logic        last_coeff;
  logic [6:0]  slot_addr;

  logic        fifo_rd_en_c;
  logic        wr_en_n_c;
  logic [2:0]  wr_addr_n_c;
  logic [4:0]  wr_data_n_c;
  logic        wr_en_s_c;
  logic [6:0]  wr_addr_s_c;
  logic [15:0] wr_data_s_c;
  logic        done_c;

  // Full 16-bit compare: a token like 16'h0102 must be rejected even though its low bits look legal.
  assign n_ok       = (bus.fifo_in_data <= 16'(MAX_N));
  assign last_coeff = (i_q == n_q);
  assign slot_addr  = (7'(a_q) * 7'd11) + 7'(i_q);

  always_comb begin
    state_d      = state;
    fifo_rd_en_c = 1'b0;
    wr_en_n_c    = 1'b0;
    wr_addr_n_c  = 3'd0;
    wr_data_n_c  = 5'd0;
    wr_en_s_c    = 1'b0;
    wr_addr_s_c  = 7'd0;
    wr_data_s_c  = 16'd0;
    done_c       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start_stc) state_d = S_RD_N;
      end
      S_RD_N: begin
        if (!bus.fifo_empty) begin
          fifo_rd_en_c = 1'b1;
          state_d      = S_CHK_N;
        end
      end
      S_CHK_N: begin
        wr_en_n_c   = 1'b1;
        wr_addr_n_c = a_q;
        wr_data_n_c = n_ok ? bus.fifo_in_data[4:0] : 5'(ERR_N);
        state_d     = n_ok ? S_RD_C : S_END;
      end
      S_RD_C: begin
        if (!bus.fifo_empty) begin
          fifo_rd_en_c = 1'b1;
          state_d      = S_WR_C;
        end
      end
      S_WR_C: begin
        wr_en_s_c   = 1'b1;
        wr_addr_s_c = slot_addr;
        wr_data_s_c = bus.fifo_in_data;
        if (last_coeff) begin
`ifdef STC_ZERO_FILL_EN
          state_d = (n_q == 4'(MAX_N)) ? S_END : S_ZFILL;
`else
          state_d = S_END;
`endif
        end else begin
          state_d = S_RD_C;
        end
      end
`ifdef STC_ZERO_FILL_EN
      S_ZFILL: begin
        wr_en_s_c   = 1'b1;
        wr_addr_s_c = slot_addr;
        state_d     = (i_q == 4'(MAX_N)) ? S_END : S_ZFILL;
      end
`endif
      S_END: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      a_q      <= 3'd0;
      n_q      <= 4'd0;
      i_q      <= 4'd0;
      status_q <= 32'hFFFF_FFFF;
    end else begin
      state <= state_d;
      case (state)
        S_IDLE: if (bus.start_stc) a_q <= bus.A;
        S_CHK_N: begin
          if (n_ok) begin
            n_q <= bus.fifo_in_data[3:0];
            i_q <= 4'd0;
          end else begin
            status_q <= 32'd1;
          end
        end
        // i keeps counting past N so zero-fill starts at slot N+1.
        S_WR_C: begin
          i_q <= i_q + 4'd1;
          if (last_coeff) status_q <= 32'd0;
        end
`ifdef STC_ZERO_FILL_EN
        S_ZFILL: i_q <= i_q + 4'd1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.fifo_rd_en = fifo_rd_en_c;
  assign bus.wr_en_N    = wr_en_n_c;
  assign bus.wr_addr_N  = wr_addr_n_c;
  assign bus.wr_data_N  = wr_data_n_c;
  assign bus.wr_en_S    = wr_en_s_c;
  assign bus.wr_addr_S  = wr_addr_s_c;
  assign bus.wr_data_S  = wr_data_s_c;
  assign bus.done_stc   = done_c;
  assign bus.status     = status_q;

endmodule
